// File: rtl/int_pkg.sv
// Shared types and constants for the integer issue unit: ALU opcodes, CDB layout,
// reservation-station entry format and the wrap-aware age comparison.
package int_pkg;

    localparam int CDB_W     = 38;
    localparam int ROB_TAG_W = 6;
    localparam int DATA_W    = 32;
    localparam int SEQ_W     = 4;

    localparam logic [ROB_TAG_W-1:0] NO_TAG = 6'd0;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLL  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        SLT  = 4'd8,
        SLTU = 4'd9
    } alu_op_t;

    // An unresolved source keeps its ROB tag in the low bits of the operand field.
    typedef struct packed {
        logic                 valid;
        alu_op_t              op;
        logic [ROB_TAG_W-1:0] rob_dest;
        logic                 src1_valid;
        logic [DATA_W-1:0]    src1;
        logic                 src2_valid;
        logic [DATA_W-1:0]    src2;
        logic [SEQ_W-1:0]     seq;
    } rs_entry_t;

    // True when sequence a was stamped before b, valid while live entries span < 8 stamps.
    function automatic logic seq_older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
        logic [SEQ_W-1:0] diff;
        diff = a - b;
        return diff[SEQ_W-1];
    endfunction

endpackage

// File: rtl/integer_alu.sv
// Single-cycle combinational integer ALU; unknown opcodes produce zero.
module integer_alu
    import int_pkg::*;
(
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ADD:     result = a + b;
            SUB:     result = a - b;
            AND:     result = a & b;
            OR:      result = a | b;
            XOR:     result = a ^ b;
            SLL:     result = a << b[4:0];
            SRL:     result = a >> b[4:0];
            SRA:     result = $unsigned($signed(a) >>> b[4:0]);
            SLT:     result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            SLTU:    result = {{(DATA_W-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/integer_issue_unit.sv
// Integer reservation station with oldest-ready select and registered CDB broadcast.
// Define INT_IU_BYPASS_EN to let select consume the live CDB value in the broadcast cycle.
module integer_issue_unit
    import int_pkg::*;
#(
    parameter int unsigned RS_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dp_to_rs,
    input  logic [3:0]           dp_alu_op,
    input  logic [ROB_TAG_W-1:0] dp_rob_dest,
    input  logic                 dp_src1_valid,
    input  logic [DATA_W-1:0]    dp_src1,
    input  logic                 dp_src2_valid,
    input  logic [DATA_W-1:0]    dp_src2,
    output logic                 rs_is_full,
    output logic [CDB_W-1:0]     cdb_integer
);

    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    rs_entry_t            rs_q [RS_DEPTH];
    logic [SEQ_W-1:0]     seq_q;

    logic [ROB_TAG_W-1:0] cdb_tag;
    logic [DATA_W-1:0]    cdb_data;
    logic                 cdb_live;

    logic [RS_DEPTH-1:0]  valid_vec;
    logic [RS_DEPTH-1:0]  ready_vec;
    logic [DATA_W-1:0]    opa [RS_DEPTH];
    logic [DATA_W-1:0]    opb [RS_DEPTH];

    logic                 issue_vld;
    logic [IDX_W-1:0]     issue_idx;
    logic                 free_vld;
    logic [IDX_W-1:0]     free_idx;
    logic                 alloc;
    rs_entry_t            new_entry;
    logic [DATA_W-1:0]    alu_result;

    assign cdb_tag    = cdb_integer[CDB_W-1:DATA_W];
    assign cdb_data   = cdb_integer[DATA_W-1:0];
    assign cdb_live   = (cdb_tag != NO_TAG);
    assign rs_is_full = &valid_vec;
    assign alloc      = dp_to_rs && !rs_is_full;

    // Operand readiness; with bypass a source matching the live CDB tag is ready now.
    always_comb begin
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            logic r1;
            logic r2;
            valid_vec[i] = rs_q[i].valid;
            r1     = rs_q[i].src1_valid;
            r2     = rs_q[i].src2_valid;
            opa[i] = rs_q[i].src1;
            opb[i] = rs_q[i].src2;
`ifdef INT_IU_BYPASS_EN
            if (!rs_q[i].src1_valid && cdb_live && rs_q[i].src1[ROB_TAG_W-1:0] == cdb_tag) begin
                r1     = 1'b1;
                opa[i] = cdb_data;
            end
            if (!rs_q[i].src2_valid && cdb_live && rs_q[i].src2[ROB_TAG_W-1:0] == cdb_tag) begin
                r2     = 1'b1;
                opb[i] = cdb_data;
            end
`endif
            ready_vec[i] = rs_q[i].valid && r1 && r2;
        end
    end

    always_comb begin
        issue_vld = 1'b0;
        issue_idx = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (ready_vec[i] && (!issue_vld || seq_older(rs_q[i].seq, rs_q[issue_idx].seq))) begin
                issue_vld = 1'b1;
                issue_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        free_vld = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (!rs_q[i].valid && !free_vld) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // A source whose tag is on the CDB right now is captured as a value at dispatch.
    always_comb begin
        new_entry          = '0;
        new_entry.valid    = 1'b1;
        new_entry.op       = alu_op_t'(dp_alu_op);
        new_entry.rob_dest = dp_rob_dest;
        new_entry.seq      = seq_q;
        new_entry.src1     = dp_src1;
        new_entry.src2     = dp_src2;
        new_entry.src1_valid = dp_src1_valid;
        new_entry.src2_valid = dp_src2_valid;
        if (!dp_src1_valid && cdb_live && dp_src1[ROB_TAG_W-1:0] == cdb_tag) begin
            new_entry.src1_valid = 1'b1;
            new_entry.src1       = cdb_data;
        end
        if (!dp_src2_valid && cdb_live && dp_src2[ROB_TAG_W-1:0] == cdb_tag) begin
            new_entry.src2_valid = 1'b1;
            new_entry.src2       = cdb_data;
        end
    end

    integer_alu u_alu (
        .op     (rs_q[issue_idx].op),
        .a      (opa[issue_idx]),
        .b      (opb[issue_idx]),
        .result (alu_result)
    );

    // Allocation only targets an invalid slot and wakeup/issue only valid ones, so the writes never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                rs_q[i] <= '0;
            end
            seq_q       <= '0;
            cdb_integer <= '0;
        end else begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                if (rs_q[i].valid && cdb_live) begin
                    if (!rs_q[i].src1_valid && rs_q[i].src1[ROB_TAG_W-1:0] == cdb_tag) begin
                        rs_q[i].src1_valid <= 1'b1;
                        rs_q[i].src1       <= cdb_data;
                    end
                    if (!rs_q[i].src2_valid && rs_q[i].src2[ROB_TAG_W-1:0] == cdb_tag) begin
                        rs_q[i].src2_valid <= 1'b1;
                        rs_q[i].src2       <= cdb_data;
                    end
                end
            end
            if (issue_vld) begin
                rs_q[issue_idx].valid <= 1'b0;
            end
            if (alloc && free_vld) begin
                rs_q[free_idx] <= new_entry;
                seq_q          <= seq_q + 1'b1;
            end
            cdb_integer <= issue_vld ? {rs_q[issue_idx].rob_dest, alu_result} : '0;
        end
    end

endmodule

// File: tb/tb_integer_issue_unit.sv
// Directed bench for integer_issue_unit with a cycle-stamped scoreboard of CDB broadcasts.
module tb_integer_issue_unit;
    import int_pkg::*;

`ifdef INT_IU_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        dp_to_rs;
    logic [3:0]  dp_alu_op;
    logic [5:0]  dp_rob_dest;
    logic        dp_src1_valid;
    logic [31:0] dp_src1;
    logic        dp_src2_valid;
    logic [31:0] dp_src2;
    logic        rs_is_full;
    logic [37:0] cdb_integer;

    integer_issue_unit #(.RS_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .dp_to_rs      (dp_to_rs),
        .dp_alu_op     (dp_alu_op),
        .dp_rob_dest   (dp_rob_dest),
        .dp_src1_valid (dp_src1_valid),
        .dp_src1       (dp_src1),
        .dp_src2_valid (dp_src2_valid),
        .dp_src2       (dp_src2),
        .rs_is_full    (rs_is_full),
        .cdb_integer   (cdb_integer)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [37:0] val;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int total = 0;
    int bad = 0;
    int accepted = 0;

    function automatic void push_exp(input logic [5:0] rob, input logic [31:0] data, input int at);
        exp_t x;
        x.val = {rob, data};
        x.at  = at;
        exp_q.push_back(x);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        dp_to_rs = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive(input logic [3:0] op, input logic [5:0] rob,
                         input logic v1, input logic [31:0] s1,
                         input logic v2, input logic [31:0] s2);
        dp_to_rs      = 1'b1;
        dp_alu_op     = op;
        dp_rob_dest   = rob;
        dp_src1_valid = v1;
        dp_src1       = s1;
        dp_src2_valid = v2;
        dp_src2       = s2;
        accepted++;
        tick();
    endtask

    // Every live broadcast must match the head of the scoreboard in value and cycle.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (cdb_integer[37:32] !== 6'd0) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_bcast got=%h exp=none", cdb_integer);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    total++;
                    assert (cdb_integer === e.val) else begin
                        bad++;
                        $error("FAIL cdb_value got=%h exp=%h", cdb_integer, e.val);
                    end
                    total++;
                    assert (cyc === e.at) else begin
                        bad++;
                        $error("FAIL cdb_cycle tag=%0d got=%0d exp=%0d", e.val[37:32], cyc, e.at);
                    end
                end
            end else begin
                total++;
                assert (cdb_integer[31:0] === 32'd0) else begin
                    bad++;
                    $error("FAIL idle_data got=%h exp=0", cdb_integer[31:0]);
                end
            end
        end
    end

    logic [3:0]  t_op [10] = '{4'd7, 4'd8, 4'd9, 4'd0, 4'd5, 4'd6, 4'd2, 4'd3, 4'd4, 4'hC};
    logic [31:0] t_a  [10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3,
                               32'h8000_0000, 32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_A5A5, 32'd5};
    logic [31:0] t_b  [10] = '{32'd4, 32'd1, 32'd1, 32'd1, 32'h21,
                               32'd4, 32'h0000_FF00, 32'h0000_0F0F, 32'h0000_FFFF, 32'd7};
    logic [31:0] t_r  [10] = '{32'hF800_0000, 32'd1, 32'd0, 32'd0, 32'd6,
                               32'h0800_0000, 32'h0000_F000, 32'h0000_FFFF, 32'h0000_5A5A, 32'd0};

    task automatic age_test(input logic [5:0] base);
        int n;
        n = cyc;
        push_exp(base, 32'd42, n + 2);
        push_exp(base + 6'd1, 32'd43, n + 4 - BYP);
        push_exp(base + 6'd2, 32'd40, n + 5 - BYP);
        drive(ADD, base, 1'b1, 32'd40, 1'b1, 32'd2);
        drive(ADD, base + 6'd1, 1'b0, {26'd0, base}, 1'b1, 32'd1);
        drive(SUB, base + 6'd2, 1'b0, {26'd0, base}, 1'b1, 32'd2);
        idle(8);
    endtask

    initial begin
        int n;
        logic [31:0] v;
        reset         = 1'b0;
        dp_to_rs      = 1'b0;
        dp_alu_op     = '0;
        dp_rob_dest   = '0;
        dp_src1_valid = 1'b0;
        dp_src1       = '0;
        dp_src2_valid = 1'b0;
        dp_src2       = '0;

        #12;
        total++;
        assert (cdb_integer === 38'd0) else begin
            bad++;
            $error("FAIL reset_cdb got=%h exp=0", cdb_integer);
        end
        total++;
        assert (rs_is_full === 1'b0) else begin
            bad++;
            $error("FAIL reset_full got=%b exp=0", rs_is_full);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);

        // Single ADD
        n = cyc;
        push_exp(6'd3, 32'd12, n + 2);
        drive(ADD, 6'd3, 1'b1, 32'd5, 1'b1, 32'd7);
        idle(5);

        // Dependency chain
        n = cyc;
        push_exp(6'd4, 32'd7, n + 2);
        push_exp(6'd5, 32'd8, n + 4 - BYP);
        drive(SUB, 6'd4, 1'b1, 32'd10, 1'b1, 32'd3);
        drive(ADD, 6'd5, 1'b0, 32'd4, 1'b1, 32'd1);
        idle(6);

        // Dispatch while the producer's tag is on the CDB
        n = cyc;
        push_exp(6'd7, 32'd3, n + 2);
        push_exp(6'd8, 32'd13, n + 4);
        drive(ADD, 6'd7, 1'b1, 32'd1, 1'b1, 32'd2);
        tick();
        drive(ADD, 6'd8, 1'b0, 32'd7, 1'b1, 32'd10);
        idle(5);

        // ALU corners, back to back
        n = cyc;
        for (int k = 0; k < 10; k++) begin
            push_exp(6'(16 + k), t_r[k], n + k + 2);
            drive(t_op[k], 6'(16 + k), 1'b1, t_a[k], 1'b1, t_b[k]);
        end
        idle(5);

        // Fill, ignored 5th dispatch, oldest-first drain
        n = cyc;
        push_exp(6'd9, 32'd105, n + 5);
        push_exp(6'd10, 32'd106, n + 7 - BYP);
        push_exp(6'd11, 32'd100, n + 8 - BYP);
        push_exp(6'd12, 32'h96, n + 9 - BYP);
        drive(ADD, 6'd10, 1'b0, 32'd9, 1'b1, 32'd1);
        drive(SUB, 6'd11, 1'b0, 32'd9, 1'b1, 32'd5);
        drive(XOR, 6'd12, 1'b0, 32'd9, 1'b1, 32'd255);
        total++;
        assert (rs_is_full === 1'b0) else begin
            bad++;
            $error("FAIL full_at3 got=%b exp=0", rs_is_full);
        end
        drive(ADD, 6'd9, 1'b1, 32'd100, 1'b1, 32'd5);
        total++;
        assert (rs_is_full === 1'b1) else begin
            bad++;
            $error("FAIL full_at4 got=%b exp=1", rs_is_full);
        end
        drive(ADD, 6'd13, 1'b1, 32'd1, 1'b1, 32'd1);
        accepted--;
        idle(8);
        total++;
        assert (rs_is_full === 1'b0) else begin
            bad++;
            $error("FAIL full_drained got=%b exp=0", rs_is_full);
        end

        // Age order without and with sequence wrap
        age_test(6'd32);
        n = cyc;
        while (accepted % 16 != 14) begin
            v = 32'(accepted);
            push_exp(6'd30, v, cyc + 2);
            drive(ADD, 6'd30, 1'b1, v, 1'b1, 32'd0);
        end
        idle(4);
        age_test(6'd36);

        // Reset with 3 held entries and a live broadcast
        drive(ADD, 6'd50, 1'b0, 32'd41, 1'b1, 32'd1);
        drive(ADD, 6'd51, 1'b0, 32'd41, 1'b1, 32'd2);
        drive(ADD, 6'd52, 1'b0, 32'd41, 1'b1, 32'd3);
        drive(ADD, 6'd41, 1'b1, 32'd1, 1'b1, 32'd1);
        tick();
        total++;
        assert (cdb_integer === {6'd41, 32'd2}) else begin
            bad++;
            $error("FAIL pre_reset_cdb got=%h exp=%h", cdb_integer, {6'd41, 32'd2});
        end
        #1;
        reset = 1'b0;
        #1;
        total++;
        assert (cdb_integer === 38'd0) else begin
            bad++;
            $error("FAIL midreset_cdb got=%h exp=0", cdb_integer);
        end
        total++;
        assert (rs_is_full === 1'b0) else begin
            bad++;
            $error("FAIL midreset_full got=%b exp=0", rs_is_full);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(10);

        n = cyc;
        push_exp(6'd63, 32'h8000_0000, n + 2);
        drive(ADD, 6'd63, 1'b1, 32'h7FFF_FFFF, 1'b1, 32'd1);

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) tick();
        idle(3);
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL missing_bcast got=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
